mmu_result_collector: RTL and testbench
=======================================

// Module: mmu_result_collector
// PURPOSE
//  Receiving end of the MATRIX_MULTIPLY_UNIT output bus. Captures the diagonally skewed
//  per-column partial sums (aout), de-skews them into aligned result rows, saturates
//  each lane to the output width, and buffers rows in a small FIFO.
//  Rows drain over a valid/ready stream toward the result writeback path.
// PARAMETERS
//  LANES       16  number of MMU output columns (lanes)
//  DW          20  width of each signed MMU output lane
//  OW          16  width of each signed output lane after saturation (OW <= DW)
//  FIFO_DEPTH  4   aligned-row FIFO entries (power of two, >= 2)
// PORTS
//  clk        in   1            rising-edge clock
//  reset_n    in   1            asynchronous active-low reset
//  in_valid   in   1            lane 0 of a new result row is present on ain this cycle
//  ain        in   LANES*DW     MMU aout bus; lane k at bits [k*DW +: DW], signed
//  clr        in   1            synchronous clear of overflow flag and row_count
//  out_valid  out  1            FIFO head row available
//  out_ready  in   1            consumer accepts head row when out_valid & out_ready
//  out_data   out  LANES*OW     aligned saturated row; lane k at [k*OW +: OW]
//  overflow   out  1            sticky: a completed row was dropped because the FIFO was full
//  row_count  out  16           rows accepted by consumer, wraps 0xFFFF -> 0x0000
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, out_data=0, overflow=0, row_count=0;
//    de-skew pipeline, valid shift chain and FIFO pointers cleared. Reset mid-row
//    discards all partial rows; no row completes from data sampled before reset.
//  - Input timing: for a row whose in_valid is sampled at edge t, lane k is sampled
//    on edge t+k. in_valid may be high every cycle (one row per cycle, fully pipelined).
//  - De-skew: lane k passes through LANES-1-k register stages; lane LANES-1 has none.
//    A valid shift chain of LANES-1 stages tracks in_valid. The row is complete in the
//    cycle of edge t+LANES-1 and is pushed into the FIFO on that edge.
//  - Latency: out_valid rises in the cycle after edge t+LANES-1 (LANES cycles after the
//    in_valid cycle) when the FIFO was empty. out_data is driven from registered FIFO
//    storage.
//  - Saturation per lane, signed: v > 2^(OW-1)-1 -> 2^(OW-1)-1;
//    v < -2^(OW-1) -> -2^(OW-1); otherwise sign-truncate to OW bits. OW==DW passes through.
//  - Handshake: pop on out_valid & out_ready. out_data stays stable while
//    out_valid & !out_ready. out_valid=0 exactly when the FIFO is empty.
//    out_data holds its last value when empty and is not meaningful then.
//  - Full: a push with the FIFO full and no same-cycle pop drops the new row and sets
//    overflow (sticky). Push and pop in the same cycle while full both take effect; no drop.
//  - Empty: a push into an empty FIFO cannot pop in the same cycle (no bypass).
//  - Pointers: log2(FIFO_DEPTH)+1 bits each; full/empty decoded from the MSB; wrap is
//    modulo 2*FIFO_DEPTH.
//  - row_count increments on each pop. clr zeroes row_count and overflow. If clr and a
//    pop coincide, row_count becomes 0. If clr and a drop coincide, overflow becomes 1.
//  - clr does not affect the FIFO or the de-skew pipeline.
// TESTING
//  1 single row: in_valid 1 cycle, lane k = k+1 on cycle t+k, out_ready=1
//    -> out_valid at t+16 for 1 cycle, lane k = k+1, row_count=1.
//  2 saturation: lane0=20'h0FFFF (65535), lane1=20'hF0000 (-65536), lane2=-5
//    -> out lanes 0x7FFF, 0x8000, 0xFFFB.
//  3 back-to-back: 8 rows on consecutive cycles, row r lane k = 16*r+k, out_ready=1
//    -> 8 consecutive out_valid cycles in order, no overflow, row_count=8.
//  4 full: out_ready=0, 5 rows with FIFO_DEPTH=4 -> 4 held, 5th dropped, overflow=1;
//    then out_ready=1 -> rows 0..3 delivered in order.
//  5 push+pop while full: FIFO holds 4 rows, out_ready=1 on the edge the 5th row completes
//    -> overflow stays 0, 5 rows delivered in order.
//  6 reset mid-row: reset_n low 1 cycle at t+7 of an in-flight row
//    -> no out_valid; all outputs 0 until the next row is sent; the next row passes correctly.

Source files
------------

// File: rtl/mmu_result_collector.sv
// mmu_result_collector: de-skews MMU output lanes, saturates them and buffers aligned rows in a FIFO
module mmu_result_collector #(
    parameter int LANES      = 16,
    parameter int DW         = 20,
    parameter int OW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [LANES*DW-1:0]   ain,
    input  logic                  clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*OW-1:0]   out_data,
    output logic                  overflow,
    output logic [15:0]           row_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0]       lane_row [LANES];
    logic [LANES*OW-1:0] sat_row;

    genvar k;
    for (k = 0; k < LANES; k++) begin : g_lane
        if (k < LANES - 1) begin : g_dly
            localparam int D = LANES - 1 - k;
            logic [DW-1:0] pipe_q [D];
            logic [DW-1:0] pipe_d [D];
            always_comb begin
                pipe_d[0] = ain[k*DW +: DW];
                for (int i = 1; i < D; i++) pipe_d[i] = pipe_q[i-1];
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) for (int i = 0; i < D; i++) pipe_q[i] <= '0;
                else          pipe_q <= pipe_d;
            end
            assign lane_row[k] = pipe_q[D-1];
        end else begin : g_pass
            assign lane_row[k] = ain[k*DW +: DW];
        end
        logic [DW-OW:0] hi;
        assign hi = lane_row[k][DW-1:OW-1];
        assign sat_row[k*OW +: OW] = (&hi || !(|hi)) ? lane_row[k][OW-1:0]
                                   : {lane_row[k][DW-1], {(OW-1){!lane_row[k][DW-1]}}};
    end

    logic [LANES-2:0]    vld_q, vld_d;
    logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
    logic [LANES*OW-1:0] mem_q [FIFO_DEPTH];
    logic [LANES*OW-1:0] mem_d [FIFO_DEPTH];
    logic                overflow_q, overflow_d;
    logic [15:0]         row_count_q, row_count_d;
    logic                push, pop, empty, full, wr_en, drop;

    assign push  = vld_q[LANES-2];
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign pop   = !empty && out_ready;
    // a full FIFO still accepts the push when the head leaves on the same edge
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        vld_d = {vld_q[LANES-3:0], in_valid};
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q[AW-1:0]] = sat_row;
        wr_d        = wr_q + (AW+1)'(wr_en);
        rd_d        = rd_q + (AW+1)'(pop);
        overflow_d  = drop || (!clr && overflow_q);
        row_count_d = clr ? 16'd0 : row_count_q + 16'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            overflow_q  <= 1'b0;
            row_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            vld_q       <= vld_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            overflow_q  <= overflow_d;
            row_count_q <= row_count_d;
            mem_q       <= mem_d;
        end
    end

    assign out_valid = !empty;
    assign out_data  = mem_q[rd_q[AW-1:0]];
    assign overflow  = overflow_q;
    assign row_count = row_count_q;
endmodule

// File: tb/tb_mmu_result_collector.sv
// tb_mmu_result_collector: directed checks of de-skew, saturation, FIFO full/empty handling and reset
module tb_mmu_result_collector;
    localparam int LANES = 16;
    localparam int DW    = 20;
    localparam int OW    = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                clr = 1'b0;
    logic                out_ready = 1'b0;
    logic [LANES*DW-1:0] ain = '0;
    logic                out_valid;
    logic                overflow;
    logic [LANES*OW-1:0] out_data;
    logic [15:0]         row_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [DW-1:0]       rows [8][LANES];
    logic [OW-1:0]       expv [8][LANES];
    logic [LANES*OW-1:0] got_q [$];
    int                  got_cyc [$];

    mmu_result_collector dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .ain       (ain),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .row_count (row_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*OW-1:0] exp_row(input int r);
        logic [LANES*OW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*OW +: OW] = expv[r][k];
        return v;
    endfunction

    task automatic set_rows(input int n, input int base);
        for (int r = 0; r < n; r++)
            for (int k = 0; k < LANES; k++) begin
                rows[r][k] = DW'(base + 16*r + k);
                expv[r][k] = OW'(base + 16*r + k);
            end
    endtask

    task automatic send(input int n, input int rdy_c, input int rst_c);
        for (int c = 0; c < n + LANES - 1; c++) begin
            in_valid = c < n;
            for (int k = 0; k < LANES; k++) begin
                int r;
                r = c - k;
                if (r >= 0 && r < n) ain[k*DW +: DW] = rows[r][k];
                else                 ain[k*DW +: DW] = 20'h5A5A5;
            end
            if (rdy_c >= 0) out_ready = (c == rdy_c);
            reset_n = (c != rst_c);
            if (c == 0) t0 = cyc;
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic wait_pops(input string tag, input int n);
        for (int i = 0; i < 200 && got_q.size() < n; i++) tick();
        repeat (3) tick();
        check({tag, "_pops"}, 256'(got_q.size()), 256'(n));
    endtask

    task automatic check_rows(input string tag, input int n);
        for (int r = 0; r < n && r < got_q.size(); r++)
            check($sformatf("%s_row%0d", tag, r), 256'(got_q[r]), 256'(exp_row(r)));
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_data", 256'(out_data), 256'(0));
        check("rst_ovf", 256'(overflow), 256'(0));
        check("rst_cnt", 256'(row_count), 256'(0));
        reset_n = 1'b1;
        tick();

        // single row, latency and count
        for (int k = 0; k < LANES; k++) begin
            rows[0][k] = DW'(k + 1);
            expv[0][k] = OW'(k + 1);
        end
        out_ready = 1'b1;
        send(1, -1, -1);
        wait_pops("t1", 1);
        check_rows("t1", 1);
        check("t1_latency", 256'(got_cyc.size() > 0 ? got_cyc[0] - t0 : -1), 256'(16));
        check("t1_cnt", 256'(row_count), 256'(1));
        check("t1_valid_low", 256'(out_valid), 256'(0));

        // saturation
        clear();
        rows[0] = '{20'h0FFFF, 20'hF0000, 20'hFFFFB, 20'h7FFFF, 20'h80000, 20'h07FFF,
                    20'hF8000, 20'hF7FFF, 20'h08000, 20'hFFFFF, 20'd10, 20'd11,
                    20'd12, 20'd13, 20'd14, 20'd15};
        expv[0] = '{16'h7FFF, 16'h8000, 16'hFFFB, 16'h7FFF, 16'h8000, 16'h7FFF,
                    16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'd10, 16'd11,
                    16'd12, 16'd13, 16'd14, 16'd15};
        send(1, -1, -1);
        wait_pops("t2", 1);
        check_rows("t2", 1);

        // back-to-back rows
        clear();
        check("t3_cnt_clr", 256'(row_count), 256'(0));
        set_rows(8, 0);
        send(8, -1, -1);
        wait_pops("t3", 8);
        check_rows("t3", 8);
        for (int i = 1; i < got_cyc.size(); i++)
            check($sformatf("t3_gap%0d", i), 256'(got_cyc[i] - got_cyc[i-1]), 256'(1));
        check("t3_ovf", 256'(overflow), 256'(0));
        check("t3_cnt", 256'(row_count), 256'(8));

        // full FIFO drops the fifth row
        clear();
        out_ready = 1'b0;
        set_rows(5, 'h100);
        send(5, -1, -1);
        check("t4_ovf", 256'(overflow), 256'(1));
        check("t4_valid", 256'(out_valid), 256'(1));
        check("t4_head", 256'(out_data), 256'(exp_row(0)));
        repeat (3) tick();
        check("t4_head_stable", 256'(out_data), 256'(exp_row(0)));
        out_ready = 1'b1;
        wait_pops("t4", 4);
        check_rows("t4", 4);
        check("t4_empty", 256'(out_valid), 256'(0));
        check("t4_cnt", 256'(row_count), 256'(4));
        check("t4_ovf_sticky", 256'(overflow), 256'(1));
        clear();
        check("t4_ovf_clr", 256'(overflow), 256'(0));

        // push and pop on the same edge while full
        set_rows(5, 'h200);
        send(5, 19, -1);
        check("t5_ovf", 256'(overflow), 256'(0));
        check("t5_cnt_mid", 256'(row_count), 256'(1));
        out_ready = 1'b1;
        wait_pops("t5", 5);
        check_rows("t5", 5);
        check("t5_ovf_end", 256'(overflow), 256'(0));
        check("t5_cnt", 256'(row_count), 256'(5));

        // reset in the middle of a row
        got_q.delete();
        got_cyc.delete();
        set_rows(1, 'h300);
        send(1, -1, 7);
        repeat (20) tick();
        check("t6_pops", 256'(got_q.size()), 256'(0));
        check("t6_valid", 256'(out_valid), 256'(0));
        check("t6_data", 256'(out_data), 256'(0));
        check("t6_ovf", 256'(overflow), 256'(0));
        check("t6_cnt", 256'(row_count), 256'(0));
        set_rows(1, 'h380);
        send(1, -1, -1);
        wait_pops("t6_next", 1);
        check_rows("t6_next", 1);
        check("t6_next_cnt", 256'(row_count), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
